mul_shift_seq_ctrl: RTL and testbench
=====================================

// Module: mul_shift_seq_ctrl
// PURPOSE
//  Sequencer in front of and behind the N-bit shift multiplier core. Takes operand pairs on a
//  valid/ready request port, loads the core by holding its active-low load/reset, waits for
//  its end flag and captures the product. Presents the product on a valid/ready response port.
//  A timeout flags a core that never finishes.
// PARAMETERS
//  DATA_WIDTH  8    operand width; product width is 2*DATA_WIDTH
//  TIMEOUT     64   max RUN cycles before abort; must be > DATA_WIDTH+1
// PORTS
//  i_clk         in   1      clock, rising edge
//  i_rst         in   1      asynchronous, active-high reset
//  i_req_valid   in   1      request operands valid
//  o_req_ready   out  1      block can accept a request
//  i_req_x       in   DW     multiplicand
//  i_req_y       in   DW     multiplier
//  o_mul_rst_n   out  1      to core i_rst_n: low = load operands / hold idle
//  o_mul_x       out  DW     to core i_num_x (registered)
//  o_mul_y       out  DW     to core i_num_y (registered)
//  i_mul_end     in   1      from core o_end
//  i_mul_res     in   2*DW   from core o_res; valid while i_mul_end=1
//  o_rsp_valid   out  1      product valid
//  i_rsp_ready   in   1      consumer takes the product
//  o_rsp_res     out  2*DW   captured product
//  o_rsp_err     out  1      qualifies o_rsp_valid; 1 = timeout, o_rsp_res=0
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; o_req_ready=0 while i_rst=1, then 1 from IDLE.
//    o_mul_rst_n=0; o_mul_x/o_mul_y=0; o_rsp_valid=0; o_rsp_res=0; o_rsp_err=0; cnt=0.
//  - FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state.
//  - IDLE: o_req_ready=1, o_mul_rst_n=0. A request handshake (i_req_valid & o_req_ready)
//    registers X/Y into o_mul_x/o_mul_y and moves to LOAD.
//  - LOAD (exactly 1 cycle): o_mul_rst_n=0, so the core samples the stable registered operands.
//    Clears cnt. Moves to RUN.
//  - RUN: o_mul_rst_n=1 and cnt increments each cycle.
//    - On i_mul_end=1: capture i_mul_res into o_rsp_res, set o_rsp_err=0, go to DONE.
//    - Else, if cnt==TIMEOUT-1: set o_rsp_res=0 and o_rsp_err=1, go to DONE.
//    - If both hold in the same cycle, end wins.
//  - DONE: o_rsp_valid=1 and o_mul_rst_n=0, which parks the core. o_rsp_res/o_rsp_err stay
//    stable until the response handshake. On i_rsp_valid&i_rsp_ready go to IDLE: o_rsp_valid
//    drops next cycle; o_rsp_res/o_rsp_err hold their last value.
//  - o_req_ready=1 only in IDLE, so there is one operation in flight and no queueing.
//  - Latency, with the core finishing normally and i_rsp_ready held high:
//    - request accept at cycle 0, LOAD at 1, core end after DATA_WIDTH+1 RUN cycles;
//    - o_rsp_valid rises DATA_WIDTH+3 cycles after accept;
//    - next request is accepted 1 cycle after the response handshake.
//  - i_req_x/i_req_y are don't-care outside the handshake cycle. o_mul_x/y change only in IDLE.
//  - Widths: cnt is $clog2(TIMEOUT+1) bits, unsigned. Products pass through bit-exact, with no
//    sign handling here.
//  - i_mul_end seen outside RUN is ignored.
//  - Reset asserted mid-operation aborts immediately. Any partial result is dropped and no
//    response is issued.
// STRUCTURE
//  - Package mul_seq_pkg holds the state enum typedef (IDLE/LOAD/RUN/DONE) and the default
//    TIMEOUT localparam.
//  - Single module with no sub-modules. The multiplier core is instantiated beside it at the
//    parent level, not inside it.
// TESTING
//  - Bench pairs this block with the real shift multiplier core, DW=8.
//  - Single op: X=3, Y=5, rsp_ready=1 -> o_rsp_valid after DW+3 cycles, o_rsp_res=15, err=0.
//  - Backpressure: X=7, Y=9, rsp_ready=0 for 10 cycles -> valid held, res=63 stable, req_ready=0;
//    raising ready completes the handshake and req_ready=1 next cycle.
//  - Back-to-back: 20 random pairs with valid held high -> one result per op, in order,
//    matching the golden X*Y. No request is accepted outside IDLE.
//  - Timeout: stub core with i_mul_end tied 0, TIMEOUT=64 -> valid after LOAD+64 cycles,
//    err=1, res=0.
//  - Reset mid-RUN: assert i_rst at RUN cycle 4 -> all outputs take reset values immediately.
//    After release, a new op X=2, Y=2 returns 4 with no stale response.
//  - Race: stub asserts i_mul_end on the cycle cnt==TIMEOUT-1 -> err=0, res=stub value.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the shift-multiplier sequencer.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mul_shift_seq_ctrl.sv
// Request/response sequencer around the shift multiplier core: loads operands,
// waits for the core end flag (or a timeout), then holds the product until taken.
module mul_shift_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [DATA_WIDTH-1:0]   i_req_x,
  input  logic [DATA_WIDTH-1:0]   i_req_y,
  output logic                    o_mul_rst_n,
  output logic [DATA_WIDTH-1:0]   o_mul_x,
  output logic [DATA_WIDTH-1:0]   o_mul_y,
  input  logic                    i_mul_end,
  input  logic [2*DATA_WIDTH-1:0] i_mul_res,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [2*DATA_WIDTH-1:0] o_rsp_res,
  output logic                    o_rsp_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = (cnt == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req_valid) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (i_mul_end || timeout_hit) state_d = DONE;
      DONE:    if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is also gated by the raw reset so nothing is offered while it is held.
  always_comb begin
    o_req_ready = 1'b0;
    o_mul_rst_n = 1'b0;
    o_rsp_valid = 1'b0;
    case (state_q)
      IDLE:    o_req_ready = !i_rst;
      RUN:     o_mul_rst_n = 1'b1;
      DONE:    o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      o_mul_x   <= '0;
      o_mul_y   <= '0;
      o_rsp_res <= '0;
      o_rsp_err <= 1'b0;
      cnt       <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (i_req_valid) begin
            o_mul_x <= i_req_x;
            o_mul_y <= i_req_y;
          end
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          // End takes priority when it coincides with the last allowed cycle.
          if (i_mul_end) begin
            o_rsp_res <= i_mul_res;
            o_rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            o_rsp_res <= '0;
            o_rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_seq_ctrl.sv
// Bench for mul_shift_seq_ctrl with a behavioural core stub and a cycle-level model.
module tb_mul_shift_seq_ctrl;

  localparam int DW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_x = '0;
  logic [DW-1:0] req_y = '0;
  logic          mul_rst_n;
  logic [DW-1:0] mul_x;
  logic [DW-1:0] mul_y;
  logic          mul_end;
  logic [2*DW-1:0] mul_res;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [2*DW-1:0] rsp_res;
  logic          rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_shift_seq_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y),
    .o_mul_rst_n(mul_rst_n), .o_mul_x(mul_x), .o_mul_y(mul_y),
    .i_mul_end(mul_end), .i_mul_res(mul_res),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_res(rsp_res), .o_rsp_err(rsp_err)
  );

  // Core stub: mode 0 = real shift core timing (end after DW+1 run cycles),
  // mode 1 = never ends, mode 2 = ends on run cycle TO-1 with a fixed value.
  int              core_mode = 0;
  logic            stray_end = 1'b0;
  logic [2*DW-1:0] stub_val = 16'hBEEF;
  int              core_cnt = 0;
  logic [DW-1:0]   cx = '0, cy = '0;
  logic            end_run;

  always @(posedge clk) begin
    if (!mul_rst_n) begin
      core_cnt <= 0;
      cx <= mul_x;
      cy <= mul_y;
    end else begin
      core_cnt <= core_cnt + 1;
    end
  end

  always_comb begin
    end_run = 1'b0;
    if (mul_rst_n) begin
      if (core_mode == 0) end_run = (core_cnt == DW + 1);
      else if (core_mode == 2) end_run = (core_cnt == TO - 1);
    end
    mul_end = end_run || stray_end;
    if (end_run) mul_res = (core_mode == 2) ? stub_val : (16'(cx) * 16'(cy));
    else mul_res = 16'hDEAD;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int core_cycles(input int mode);
    if (mode == 0) return DW + 1;
    if (mode == 2) return TO - 1;
    return 1 << 30;
  endfunction

  // Model: edges since accept; response due once the core has run (or timed out).
  bit              m_busy = 0;
  int              m_age = 0, m_lat = 0;
  logic [DW-1:0]   m_x = '0, m_y = '0;
  logic [2*DW-1:0] m_pres = '0, m_lres = '0;
  logic            m_perr = 0, m_lerr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_age = 0; m_x = '0; m_y = '0;
      m_lres = '0; m_lerr = 0; m_pres = '0; m_perr = 0;
    end else if (m_busy) begin
      if (m_age >= m_lat && rsp_ready) begin
        m_busy = 0; m_lres = m_pres; m_lerr = m_perr;
      end else begin
        m_age++;
      end
    end else if (req_valid) begin
      int endc;
      m_busy = 1; m_age = 0; m_x = req_x; m_y = req_y;
      endc = core_cycles(core_mode);
      if (endc <= TO - 1) begin
        m_lat = endc + 2;
        m_perr = 0;
        m_pres = (core_mode == 2) ? stub_val : 16'(req_x) * 16'(req_y);
      end else begin
        m_lat = TO + 1;
        m_perr = 1;
        m_pres = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic due;
    due = m_busy && (m_age >= m_lat);
    chk("req_ready", 32'(req_ready), 32'(!m_busy && !rst));
    chk("rsp_valid", 32'(rsp_valid), 32'(due));
    chk("mul_rst_n", 32'(mul_rst_n), 32'(m_busy && m_age >= 1 && m_age < m_lat));
    chk("mul_x", 32'(mul_x), 32'(m_x));
    chk("mul_y", 32'(mul_y), 32'(m_y));
    chk("rsp_res", 32'(rsp_res), 32'(due ? m_pres : m_lres));
    chk("rsp_err", 32'(rsp_err), 32'(due ? m_perr : m_lerr));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [DW-1:0] x, input logic [DW-1:0] y, output int lat);
    req_x = x; req_y = y; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  logic [DW-1:0]   bx[20], by[20];
  logic [2*DW-1:0] gq[$];

  initial begin
    int lat;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_res", 32'(rsp_res), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(req_ready), 32'd1);

    rsp_ready = 1'b1;
    issue(8'd3, 8'd5, lat);
    chk("single_lat", 32'(lat), 32'(DW + 3));
    chk("single_res", 32'(rsp_res), 32'd15);
    chk("single_err", 32'(rsp_err), 32'd0);
    tick();
    chk("single_after_valid", 32'(rsp_valid), 32'd0);
    chk("single_after_ready", 32'(req_ready), 32'd1);

    rsp_ready = 1'b0;
    issue(8'd7, 8'd9, lat);
    chk("bp_lat", 32'(lat), 32'(DW + 3));
    stray_end = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_res", 32'(rsp_res), 32'd63);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    stray_end = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    chk("bp_hold_res", 32'(rsp_res), 32'd63);

    core_mode = 1;
    issue(8'hAA, 8'h55, lat);
    chk("to_lat", 32'(lat), 32'(TO + 1));
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_res", 32'(rsp_res), 32'd0);
    tick();

    core_mode = 2;
    issue(8'h11, 8'h22, lat);
    chk("race_lat", 32'(lat), 32'(TO + 1));
    chk("race_err", 32'(rsp_err), 32'd0);
    chk("race_res", 32'(rsp_res), 32'hBEEF);
    tick();

    core_mode = 0;
    req_x = 8'h12; req_y = 8'h34; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_run", 32'(mul_rst_n), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_rstn", 32'(mul_rst_n), 32'd0);
    chk("arst_x", 32'(mul_x), 32'd0);
    chk("arst_y", 32'(mul_y), 32'd0);
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_res", 32'(rsp_res), 32'd0);
    chk("arst_err", 32'(rsp_err), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    issue(8'd2, 8'd2, lat);
    chk("post_rst_lat", 32'(lat), 32'(DW + 3));
    chk("post_rst_res", 32'(rsp_res), 32'd4);
    tick();

    for (int i = 0; i < 20; i++) begin
      bx[i] = 8'($urandom_range(0, 255));
      by[i] = 8'($urandom_range(0, 255));
    end
    bx[0] = 8'hFF; by[0] = 8'hFF;
    begin
      int idx, nresp, budget;
      logic acc, hs;
      logic [2*DW-1:0] got;
      idx = 0; nresp = 0; budget = 0;
      req_x = bx[0]; req_y = by[0]; req_valid = 1'b1;
      while (nresp < 20 && budget < 20 * (DW + 6) + 50) begin
        acc = req_valid && req_ready;
        hs = rsp_valid && rsp_ready;
        got = rsp_res;
        tick();
        budget++;
        if (hs) begin
          if (gq.size() == 0) chk("b2b_spurious", 32'(got), 32'hFFFF_FFFF);
          else chk("b2b_res", 32'(got), 32'(gq.pop_front()));
          nresp++;
        end
        if (acc) begin
          gq.push_back(16'(bx[idx]) * 16'(by[idx]));
          idx++;
          if (idx < 20) begin
            req_x = bx[idx]; req_y = by[idx];
          end else begin
            req_valid = 1'b0;
          end
        end
      end
      chk("b2b_count", 32'(nresp), 32'd20);
      chk("b2b_accepts", 32'(idx), 32'd20);
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
